// File: rtl/rvvi_event_queue_if.sv
// Trace-in lanes and event-out stream for the RVVI retire event queue.
// The master side (trace source/consumer) drives lanes and ev_ready.
interface rvvi_event_queue_if #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int RETIRE = 1
);
  logic [RETIRE-1:0]      in_valid;
  logic [63:0]            in_order   [RETIRE];
  logic [ILEN-1:0]        in_insn    [RETIRE];
  logic [XLEN-1:0]        in_pc      [RETIRE];
  logic [RETIRE-1:0]      in_trap;
  logic [1:0]             in_mode    [RETIRE];
  logic [31:0]            in_x_wb    [RETIRE];
  logic [31:0][XLEN-1:0]  in_x_wdata [RETIRE];

  logic                   ev_valid;
  logic                   ev_ready;
  logic [63:0]            ev_order;
  logic [ILEN-1:0]        ev_insn;
  logic [XLEN-1:0]        ev_pc;
  logic                   ev_trap;
  logic [1:0]             ev_mode;
  logic [4:0]             ev_rd;
  logic                   ev_rd_wen;
  logic [XLEN-1:0]        ev_rd_data;

  modport master (
    output in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_x_wb, in_x_wdata,
    output ev_ready,
    input  ev_valid, ev_order, ev_insn, ev_pc, ev_trap, ev_mode, ev_rd, ev_rd_wen, ev_rd_data
  );

  modport slave (
    input  in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_x_wb, in_x_wdata,
    input  ev_ready,
    output ev_valid, ev_order, ev_insn, ev_pc, ev_trap, ev_mode, ev_rd, ev_rd_wen, ev_rd_data
  );
endinterface

// File: rtl/rvvi_event_queue.sv
// Multi-lane RVVI retire event queue: packs valid lanes into a circular buffer,
// extracts the first GPR writeback per event, and tracks drops and order gaps.
module rvvi_event_queue #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int RETIRE = 1,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  rvvi_event_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic                     order_err,
  output logic                     multi_wb
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  logic [63:0]      q_order   [DEPTH];
  logic [ILEN-1:0]  q_insn    [DEPTH];
  logic [XLEN-1:0]  q_pc      [DEPTH];
  logic             q_trap    [DEPTH];
  logic [1:0]       q_mode    [DEPTH];
  logic [4:0]       q_rd      [DEPTH];
  logic             q_rd_wen  [DEPTH];
  logic [XLEN-1:0]  q_rd_data [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             exp_vld;
  logic [63:0]      exp_order;

  logic [31:0]      lane_wb   [RETIRE];
  logic [5:0]       lane_ones [RETIRE];
  logic [4:0]       lane_rd   [RETIRE];
  logic             lane_wen  [RETIRE];
  logic [XLEN-1:0]  lane_data [RETIRE];
  logic [AW-1:0]    lane_idx  [RETIRE];

  logic [AW:0]      vcnt;
  logic [AW:0]      free_slots;
  logic             accept;
  logic             drop;
  logic             deq;
  logic             any_multi;
  logic             order_mismatch;
  logic             exp_vld_n;
  logic [63:0]      exp_order_n;
  logic [16:0]      drop_sum;

  // Lane decode and order tracking are chained in lane order so that multiple
  // lanes retiring together are checked against each other, dropped or not.
  always_comb begin
    vcnt           = '0;
    any_multi      = 1'b0;
    order_mismatch = 1'b0;
    exp_vld_n      = exp_vld;
    exp_order_n    = exp_order;
    for (int l = 0; l < RETIRE; l++) begin
      lane_wb[l]   = bus.in_x_wb[l] & 32'hFFFF_FFFE;
      lane_rd[l]   = 5'd0;
      lane_wen[l]  = 1'b0;
      lane_ones[l] = 6'd0;
      for (int i = 31; i >= 1; i--) begin
        if (lane_wb[l][i]) begin
          lane_rd[l]  = 5'(i);
          lane_wen[l] = 1'b1;
        end
      end
      for (int i = 0; i < 32; i++) begin
        lane_ones[l] = lane_ones[l] + {5'd0, lane_wb[l][i]};
      end
      lane_data[l] = lane_wen[l] ? bus.in_x_wdata[l][lane_rd[l]] : '0;
      lane_idx[l]  = wr_ptr + vcnt[AW-1:0];
      if (bus.in_valid[l]) begin
        vcnt = vcnt + ONE_W;
        if (lane_ones[l] > 6'd1) begin
          any_multi = 1'b1;
        end
        if (exp_vld_n && (bus.in_order[l] != exp_order_n)) begin
          order_mismatch = 1'b1;
        end
        exp_order_n = bus.in_order[l] + 64'd1;
        exp_vld_n   = 1'b1;
      end
    end
    // Free space is taken at cycle start; a same-cycle dequeue is not credited.
    free_slots = DEPTH_W - occupancy;
    accept     = (vcnt <= free_slots);
    drop       = (vcnt != '0) && !accept;
    deq        = (occupancy != '0) && bus.ev_ready;
    drop_sum   = {1'b0, drop_cnt} + 17'(vcnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
      multi_wb  <= 1'b0;
      exp_vld   <= 1'b0;
      exp_order <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        q_order[d]   <= '0;
        q_insn[d]    <= '0;
        q_pc[d]      <= '0;
        q_trap[d]    <= 1'b0;
        q_mode[d]    <= '0;
        q_rd[d]      <= '0;
        q_rd_wen[d]  <= 1'b0;
        q_rd_data[d] <= '0;
      end
    end else begin
      if (accept) begin
        for (int l = 0; l < RETIRE; l++) begin
          if (bus.in_valid[l]) begin
            q_order[lane_idx[l]]   <= bus.in_order[l];
            q_insn[lane_idx[l]]    <= bus.in_insn[l];
            q_pc[lane_idx[l]]      <= bus.in_pc[l];
            q_trap[lane_idx[l]]    <= bus.in_trap[l];
            q_mode[lane_idx[l]]    <= bus.in_mode[l];
            q_rd[lane_idx[l]]      <= lane_rd[l];
            q_rd_wen[lane_idx[l]]  <= lane_wen[l];
            q_rd_data[lane_idx[l]] <= lane_data[l];
          end
        end
        wr_ptr <= wr_ptr + vcnt[AW-1:0];
      end
      if (deq) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      occupancy <= occupancy + (accept ? vcnt : '0) - (deq ? ONE_W : '0);
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (order_mismatch) begin
        order_err <= 1'b1;
      end
      if (any_multi) begin
        multi_wb <= 1'b1;
      end
      exp_vld   <= exp_vld_n;
      exp_order <= exp_order_n;
    end
  end

  assign bus.ev_valid   = (occupancy != '0);
  assign bus.ev_order   = q_order[rd_ptr];
  assign bus.ev_insn    = q_insn[rd_ptr];
  assign bus.ev_pc      = q_pc[rd_ptr];
  assign bus.ev_trap    = q_trap[rd_ptr];
  assign bus.ev_mode    = q_mode[rd_ptr];
  assign bus.ev_rd      = q_rd[rd_ptr];
  assign bus.ev_rd_wen  = q_rd_wen[rd_ptr];
  assign bus.ev_rd_data = q_rd_data[rd_ptr];

endmodule

// File: tb/tb_rvvi_event_queue.sv
// Directed bench for rvvi_event_queue with two retire lanes and 16 entries.
module tb_rvvi_event_queue;
  logic        clk;
  logic        reset_n;
  logic [4:0]  occupancy;
  logic [15:0] drop_cnt;
  logic        overflow, order_err, multi_wb;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [63:0] exp_q [$];

  rvvi_event_queue_if #(.XLEN(32), .ILEN(32), .RETIRE(2)) bus ();

  rvvi_event_queue #(.XLEN(32), .ILEN(32), .RETIRE(2), .DEPTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .order_err (order_err),
    .multi_wb  (multi_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    bus.in_valid = '0;
    bus.in_trap  = '0;
    for (int l = 0; l < 2; l++) begin
      bus.in_order[l]   = '0;
      bus.in_insn[l]    = '0;
      bus.in_pc[l]      = '0;
      bus.in_mode[l]    = '0;
      bus.in_x_wb[l]    = '0;
      bus.in_x_wdata[l] = '0;
    end
  endtask

  task automatic set_lane(input int l, input logic [63:0] ord, input logic [31:0] wb,
                          input int ri, input logic [31:0] data);
    bus.in_valid[l]       = 1'b1;
    bus.in_order[l]       = ord;
    bus.in_insn[l]        = 32'h0000_0013;
    bus.in_pc[l]          = 32'h8000_0000 + ord[31:0] * 4;
    bus.in_mode[l]        = 2'b11;
    bus.in_x_wb[l]        = wb;
    bus.in_x_wdata[l][ri] = data;
  endtask

  task automatic push1(input logic [63:0] ord);
    clr_in();
    set_lane(0, ord, 32'h0, 0, 32'h0);
    step();
    clr_in();
  endtask

  // Reset asserted and released between clock edges; state must clear at once.
  task automatic pulse_reset(input string tag);
    clr_in();
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_ev_valid"}, 64'(bus.ev_valid), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    chk({tag, "_flags"}, 64'({overflow, order_err, multi_wb}), 64'd0);
    chk({tag, "_ev_order"}, bus.ev_order, 64'd0);
    #2 reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.ev_ready = 1'b1;
    clr_in();
    // inputs must be ignored while held in reset
    set_lane(0, 64'd77, 32'h0, 0, 32'h0);
    step();
    step();
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ev_valid", 64'(bus.ev_valid), 64'd0);
    chk("rst_ev_data", {bus.ev_order[31:0], bus.ev_rd_data}, 64'd0);
    chk("rst_flags", 64'({overflow, order_err, multi_wb, drop_cnt}), 64'd0);
    clr_in();
    #2 reset_n = 1'b1;
    step();

    // single event
    set_lane(0, 64'd5, 32'h0000_0400, 10, 32'h0000_1234);
    bus.in_pc[0] = 32'h8000_0000;
    step();
    clr_in();
    chk("single_valid", 64'(bus.ev_valid), 64'd1);
    chk("single_order", bus.ev_order, 64'd5);
    chk("single_pc", 64'(bus.ev_pc), 64'h8000_0000);
    chk("single_rd", 64'(bus.ev_rd), 64'd10);
    chk("single_wen", 64'(bus.ev_rd_wen), 64'd1);
    chk("single_data", 64'(bus.ev_rd_data), 64'h1234);
    chk("single_mode", 64'(bus.ev_mode), 64'd3);
    step();
    chk("single_drained", 64'(bus.ev_valid), 64'd0);

    // bit 0 alone is not a writeback; bits 0 and 6 give rd=6 without multi
    set_lane(0, 64'd6, 32'h0000_0001, 0, 32'hDEAD_BEEF);
    step();
    clr_in();
    chk("bit0_rd", 64'({bus.ev_rd, bus.ev_rd_wen}), 64'd0);
    chk("bit0_data", 64'(bus.ev_rd_data), 64'd0);
    set_lane(0, 64'd7, 32'h0000_0041, 6, 32'h0000_0066);
    bus.in_x_wdata[0][0] = 32'hFFFF_FFFF;
    step();
    clr_in();
    chk("bit0_6_rd", 64'(bus.ev_rd), 64'd6);
    chk("bit0_6_data", 64'(bus.ev_rd_data), 64'h66);
    chk("bit0_6_multi", 64'(multi_wb), 64'd0);
    chk("bit0_6_order_err", 64'(order_err), 64'd0);
    step();

    // backpressure until full, then drain
    pulse_reset("bp_rst");
    bus.ev_ready = 1'b0;
    for (int k = 0; k < 18; k++) push1(64'(k));
    chk("bp_occ", 64'(occupancy), 64'd16);
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_drop", 64'(drop_cnt), 64'd2);
    chk("bp_order_err", 64'(order_err), 64'd0);
    chk("bp_head_stable", bus.ev_order, 64'd0);
    bus.ev_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bp_out%0d", k), bus.ev_order, 64'(k));
      step();
    end
    chk("bp_empty", 64'({bus.ev_valid, occupancy}), 64'd0);

    // order gap
    pulse_reset("gap_rst");
    push1(64'd1);
    chk("gap_e1_err", 64'(order_err), 64'd0);
    chk("gap_e1_out", bus.ev_order, 64'd1);
    push1(64'd2);
    chk("gap_e2_err", 64'(order_err), 64'd0);
    chk("gap_e2_out", bus.ev_order, 64'd2);
    push1(64'd4);
    chk("gap_e3_err", 64'(order_err), 64'd1);
    chk("gap_e3_out", bus.ev_order, 64'd4);
    push1(64'd5);
    chk("gap_e4_err", 64'(order_err), 64'd1);
    chk("gap_e4_out", bus.ev_order, 64'd5);
    step();
    chk("gap_empty", 64'(bus.ev_valid), 64'd0);

    // two lanes against one free slot, then against two; orders wrap 2^64
    pulse_reset("ml_rst");
    bus.ev_ready = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 15; k++) begin
      push1(64'hFFFF_FFFF_FFFF_FFF8 + 64'(k));
      if (k > 0) exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8 + 64'(k));
    end
    chk("ml_fill_occ", 64'(occupancy), 64'd15);
    set_lane(0, 64'd7, 32'h0, 0, 32'h0);
    set_lane(1, 64'd8, 32'h0, 0, 32'h0);
    step();
    clr_in();
    chk("ml_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ml_drop_occ", 64'(occupancy), 64'd15);
    chk("ml_drop_ovf", 64'(overflow), 64'd1);
    chk("ml_drop_order_err", 64'(order_err), 64'd0);
    bus.ev_ready = 1'b1;
    step();
    bus.ev_ready = 1'b0;
    chk("ml_free2_occ", 64'(occupancy), 64'd14);
    set_lane(0, 64'd9, 32'h0, 0, 32'h0);
    set_lane(1, 64'd10, 32'h0000_0300, 8, 32'h0000_BEEF);
    step();
    clr_in();
    exp_q.push_back(64'd9);
    exp_q.push_back(64'd10);
    chk("ml_acc_occ", 64'(occupancy), 64'd16);
    chk("ml_acc_drop", 64'(drop_cnt), 64'd2);
    chk("ml_acc_order_err", 64'(order_err), 64'd0);
    chk("ml_multi", 64'(multi_wb), 64'd1);
    bus.ev_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ml_out%0d", k), bus.ev_order, exp_q[k]);
      if (k == 15) begin
        chk("ml_lane1_rd", 64'(bus.ev_rd), 64'd8);
        chk("ml_lane1_data", 64'(bus.ev_rd_data), 64'hBEEF);
      end
      step();
    end
    chk("ml_empty", 64'(bus.ev_valid), 64'd0);

    // reset with entries queued
    bus.ev_ready = 1'b0;
    for (int k = 11; k < 16; k++) push1(64'(k));
    chk("mid_occ", 64'(occupancy), 64'd5);
    pulse_reset("mid_rst");
    step();
    step();
    chk("mid_no_ghost", 64'({bus.ev_valid, occupancy}), 64'd0);
    bus.ev_ready = 1'b1;
    push1(64'd100);
    chk("mid_new_valid", 64'(bus.ev_valid), 64'd1);
    chk("mid_new_order", bus.ev_order, 64'd100);
    chk("mid_new_order_err", 64'(order_err), 64'd0);
    step();

    // continuous enqueue and dequeue through several pointer wraps
    pulse_reset("wrap_rst");
    for (int k = 0; k < 40; k++) begin
      push1(64'(k));
      chk($sformatf("wrap_occ%0d", k), 64'(occupancy), 64'd1);
      chk($sformatf("wrap_out%0d", k), bus.ev_order, 64'(k));
    end
    step();
    chk("wrap_empty", 64'(bus.ev_valid), 64'd0);
    chk("wrap_flags", 64'({overflow, order_err, multi_wb, drop_cnt}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
